// File: rtl/fifo_pkg.sv
// State encoding shared by the stages that sit next to the interconnect sync FIFO.
package fifo_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

endpackage

// File: rtl/fifo_out_skid_stage.sv
// FIFO read-side output stage: pops FIFO beats into a 2-entry out/skid buffer and
// presents them on a registered valid/ready master port.
module fifo_out_skid_stage
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_valid_o,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [1:0]            occupancy_o
);

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  push;
    logic                  take;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        // Pop decision uses only registered state so m_ready_i never reaches the FIFO.
        push    = !rst && !flush_i && !fifo_empty_i && (state_q != ST_TWO);
        take    = m_valid_o && m_ready_i;

        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d = ST_ONE;
                        out_d   = fifo_data_i;
                    end
                end
                ST_ONE: begin
                    if (push && take) begin
                        out_d   = fifo_data_i;
                    end else if (push) begin
                        state_d = ST_TWO;
                        skid_d  = fifo_data_i;
                    end else if (take) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (take) begin
                        state_d = ST_ONE;
                        out_d   = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign fifo_rd_valid_o = push;
    assign m_valid_o       = (state_q != ST_EMPTY);
    assign m_data_o        = out_q;
    assign occupancy_o     = state_q;

endmodule

// File: tb/tb_fifo_out_skid_stage.sv
// Scoreboard bench for fifo_out_skid_stage: a behavioural FIFO feeds the stage,
// expected beats are queued when loaded and checked by a separate monitor on each take.
module tb_fifo_out_skid_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] fifo_data;
    logic       fifo_empty;
    logic       fifo_rd_valid;
    logic       flush;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [1:0] occupancy;

    logic [7:0]  fifo_mem [0:4095];
    logic [11:0] wr_ptr = '0;
    logic [11:0] rd_ptr = '0;
    logic [7:0]  exp_q [$];

    int errors = 0;
    int checks = 0;

    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data  = '0;

    assign fifo_data  = fifo_mem[rd_ptr];
    assign fifo_empty = (wr_ptr == rd_ptr);

    always #5 clk = ~clk;

    fifo_out_skid_stage #(.DATA_WIDTH(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .fifo_data_i     (fifo_data),
        .fifo_empty_i    (fifo_empty),
        .fifo_rd_valid_o (fifo_rd_valid),
        .flush_i         (flush),
        .m_data_o        (m_data),
        .m_valid_o       (m_valid),
        .m_ready_i       (m_ready),
        .occupancy_o     (occupancy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        fifo_mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 12'd1;
        exp_q.push_back(w);
    endtask

    task automatic drop_expected(input int n);
        for (int k = 0; k < n; k++) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
    endtask

    // Monitor: scoreboard on takes, stall stability, no pop from an empty FIFO.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL take_unexpected: got 0x%0h, expected no beat", m_data);
                    end else begin
                        check("take_data", 32'(m_data), 32'(exp_q.pop_front()));
                    end
                end
                if (prev_valid && !prev_ready && m_valid)
                    check("stall_stable", 32'(m_data), 32'(prev_data));
                if (fifo_rd_valid)
                    check("pop_when_empty", 32'(fifo_empty), 32'd0);
                if (fifo_rd_valid)
                    rd_ptr <= rd_ptr + 12'd1;
            end
            prev_valid = m_valid;
            prev_ready = m_ready;
            prev_data  = m_data;
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) fifo_mem[i] = '0;
        rst     = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_occ", 32'(occupancy), 32'd0);
        rst = 1'b0;

        // Async reset mid-cycle while a beat is held.
        push_word(8'h99);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_valid", 32'(m_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(m_valid), 32'd0);
        check("arst_data", 32'(m_data), 32'd0);
        check("arst_occ", 32'(occupancy), 32'd0);
        drop_expected(1);
        push_word(8'hA1);
        #1;
        check("arst_no_pop", 32'(fifo_rd_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_pop", 32'(fifo_rd_valid), 32'd1);
        m_ready = 1'b1;
        @(negedge clk);
        check("rel_valid", 32'(m_valid), 32'd1);
        check("rel_data", 32'(m_data), 32'hA1);
        @(negedge clk);
        check("rel_drained", 32'(m_valid), 32'd0);

        // Streaming 0x01..0x10 with ready held high.
        for (int i = 1; i <= 16; i++) push_word(8'(i));
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            check("stream_valid", 32'(m_valid), 32'd1);
            check("stream_data", 32'(m_data), 32'(i));
            check("stream_occ", 32'(occupancy), 32'd1);
        end
        @(negedge clk);
        check("stream_end_valid", 32'(m_valid), 32'd0);
        check("stream_end_pop", 32'(fifo_rd_valid), 32'd0);

        // Backpressure: 5 stalled cycles, then resume without gap.
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_word(8'(8'h20 + i));
        @(negedge clk);
        check("bp_occ1", 32'(occupancy), 32'd1);
        check("bp_pop1", 32'(fifo_rd_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_occ2", 32'(occupancy), 32'd2);
            check("bp_no_pop", 32'(fifo_rd_valid), 32'd0);
            check("bp_hold", 32'(m_data), 32'h20);
        end
        m_ready = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check("bp_resume_valid", 32'(m_valid), 32'd1);
            check("bp_resume_data", 32'(m_data), 32'(8'h20 + k));
        end
        @(negedge clk);
        check("bp_end_valid", 32'(m_valid), 32'd0);

        // Random ready over 1000 beats.
        for (int i = 0; i < 1000; i++) push_word(8'(i * 37 + 11));
        begin
            int cyc = 0;
            while (exp_q.size() != 0 && cyc < 20000) begin
                @(negedge clk);
                m_ready = 1'($urandom_range(0, 1));
                cyc++;
            end
        end
        check("random_drained", 32'(exp_q.size()), 32'd0);
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("random_idle", 32'(m_valid), 32'd0);

        // Flush from TWO with a word still in the FIFO.
        push_word(8'h30);
        push_word(8'h31);
        push_word(8'h32);
        @(negedge clk);
        @(negedge clk);
        check("fl_occ2", 32'(occupancy), 32'd2);
        check("fl_data", 32'(m_data), 32'h30);
        flush = 1'b1;
        drop_expected(2);
        #1;
        check("fl_no_pop", 32'(fifo_rd_valid), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        check("fl_valid", 32'(m_valid), 32'd0);
        check("fl_occ0", 32'(occupancy), 32'd0);
        #1;
        check("fl_repop", 32'(fifo_rd_valid), 32'd1);
        @(negedge clk);
        check("fl_resume_valid", 32'(m_valid), 32'd1);
        check("fl_resume_data", 32'(m_data), 32'h32);
        m_ready = 1'b1;
        @(negedge clk);
        check("fl_end_valid", 32'(m_valid), 32'd0);

        // Single entry.
        m_ready = 1'b0;
        push_word(8'h55);
        @(negedge clk);
        @(negedge clk);
        check("se_occ", 32'(occupancy), 32'd1);
        check("se_data", 32'(m_data), 32'h55);
        check("se_empty", 32'(fifo_empty), 32'd1);
        check("se_no_pop", 32'(fifo_rd_valid), 32'd0);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check("se_valid", 32'(m_valid), 32'd0);
        check("se_occ0", 32'(occupancy), 32'd0);

        repeat (2) @(negedge clk);
        check("final_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
